// File: rtl/sample_scheduler.sv
// sample_scheduler: sampling tick, ADC start/capture, delayed DAC start, overrun flag and sample counter.
// Define SAMPLE_SCHED_WDOG_EN to build the CONVERT watchdog that drives timeout.
module sample_scheduler #(
    parameter int DATA_W         = 10,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              enable,
    input  logic [15:0]       period,
    input  logic [3:0]        proc_latency,
    input  logic              clear_flags,
    output logic              adc_start,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_strobe,
    output logic              dac_start,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic [15:0]       sample_count
);
    typedef enum logic [1:0] {IDLE, CONVERT, SETTLE, OUTPUT} state_t;

    state_t      state;
    logic [15:0] tick_cnt;
    logic [3:0]  lat_cnt;
    logic        valid_q;
    logic        tick;
    logic        rise;
    logic        wd_fire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // >= compare lets a shortened period take effect without waiting out the old one
    assign tick = enable && (tick_cnt >= period);
    assign rise = adc_valid && !valid_q;

    always_ff @(posedge sysclk)
        if (reset || !enable || tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 16'd1;

`ifdef SAMPLE_SCHED_WDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    assign wd_fire = (state == CONVERT) && !rise && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge sysclk)
        if (reset || state != CONVERT) wd_cnt <= '0;
        else wd_cnt <= wd_cnt + WD_W'(1);
    always_ff @(posedge sysclk)
        if (reset) timeout <= 1'b0;
        else timeout <= wd_fire ? 1'b1 : clear_flags ? 1'b0 : timeout;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge sysclk)
        if (reset) begin
            state         <= IDLE;
            valid_q       <= 1'b0;
            lat_cnt       <= '0;
            adc_start     <= 1'b0;
            sample_strobe <= 1'b0;
            dac_start     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
            sample_out    <= '0;
            sample_count  <= '0;
        end else begin
            valid_q       <= adc_valid;
            adc_start     <= 1'b0;
            sample_strobe <= 1'b0;
            dac_start     <= 1'b0;
            overrun       <= (tick && state != IDLE) ? 1'b1 : clear_flags ? 1'b0 : overrun;
            case (state)
                IDLE:
                    if (tick) begin
                        state     <= CONVERT;
                        busy      <= 1'b1;
                        adc_start <= 1'b1;
                    end
                CONVERT:
                    if (rise) begin
                        sample_out    <= adc_data;
                        sample_strobe <= 1'b1;
                        lat_cnt       <= proc_latency;
                        state         <= SETTLE;
                    end else if (wd_fire) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                SETTLE:
                    // DAC pulse is issued on entry so it lines up with the OUTPUT cycle
                    if (lat_cnt == 4'd0) begin
                        state        <= OUTPUT;
                        dac_start    <= 1'b1;
                        sample_count <= sample_count + 16'd1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                OUTPUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
endmodule
